// File: rtl/dual_issue_scoreboard.sv
// dual_issue_scoreboard: per-register latency scoreboard and issue control for a two-slot in-order ID stage.
// Optional feature: define SB_PERF_CNT_EN to build the saturating stall_cycles performance counter.
module dual_issue_scoreboard #(
  parameter int NREG  = 8,
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             id_valid_1,
  input  logic             id_valid_2,
  input  logic [2:0]       id_rm_1,
  input  logic [2:0]       id_rn_1,
  input  logic [2:0]       id_rm_2,
  input  logic [2:0]       id_rn_2,
  input  logic [1:0]       id_src_en_1,
  input  logic [1:0]       id_src_en_2,
  input  logic [2:0]       id_rd_1,
  input  logic [2:0]       id_rd_2,
  input  logic             id_we_1,
  input  logic             id_we_2,
  input  logic [LAT_W-1:0] id_lat_1,
  input  logic [LAT_W-1:0] id_lat_2,
  output logic             issue_1,
  output logic             issue_2,
  output logic [NREG-1:0]  busy_mask,
  output logic [15:0]      stall_cycles
);

  // cnt[0] exists only so register addresses index directly; it is held at zero.
  logic [LAT_W-1:0] cnt [NREG];

  logic haz_1;
  logic haz_2;
  logic raw_12;
  logic waw_12;
  logic conflict;
  logic load_1;
  logic load_2;

  always_comb begin
    haz_1 = (id_src_en_1[0] && (cnt[id_rm_1] != '0)) ||
            (id_src_en_1[1] && (cnt[id_rn_1] != '0));
    haz_2 = (id_src_en_2[0] && (cnt[id_rm_2] != '0)) ||
            (id_src_en_2[1] && (cnt[id_rn_2] != '0));

    raw_12 = (id_src_en_2[0] && (id_rm_2 == id_rd_1)) ||
             (id_src_en_2[1] && (id_rn_2 == id_rd_1));
    waw_12 = id_we_2 && (id_rd_2 == id_rd_1);
    conflict = id_we_1 && (id_rd_1 != 3'd0) && (raw_12 || waw_12);

    issue_1 = id_valid_1 && !flush && !haz_1;
    issue_2 = issue_1 && id_valid_2 && !haz_2 && !conflict;

    load_1 = issue_1 && id_we_1 && (id_rd_1 != 3'd0) && (id_lat_1 != '0);
    load_2 = issue_2 && id_we_2 && (id_rd_2 != 3'd0) && (id_lat_2 != '0);
  end

  // Slot 2 is checked first so it wins a same-register load; WAW blocking makes that case unreachable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (load_2 && (id_rd_2 == 3'(r)))
          cnt[r] <= id_lat_2;
        else if (load_1 && (id_rd_1 == 3'(r)))
          cnt[r] <= id_lat_1;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int unsigned r = 0; r < NREG; r++) busy_mask[r] = (cnt[r] != '0);
  end

`ifdef SB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (id_valid_1 && !issue_1 && !flush && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 16'd1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
